vga_sync_rx: RTL and testbench

- Receive side of the VGA timing interface: consumes Hsync/Vsync from the Vga timing generator (or any 640x480-style source) and recovers the pixel position.
- Checks the recovered timing against the parameterised format, locks after consecutive good frames, and flags timing errors.
- Sits downstream of the Vga generator as a timing monitor and as a position source for pixel consumers fed only by sync signals.
- Runs on the same clk and pixel enable strobe as the generator.

---
 rtl/vga_sync_rx.sv | 165 ++++++++++++++++
 tb/tb_vga_sync_rx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel position from Hsync/Vsync,
// checks line/frame timing against the configured format and locks.
module vga_sync_rx #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        Hsync,
    input  logic        Vsync,
    output logic [10:0] Hpos,
    output logic [10:0] Vpos,
    output logic        active,
    output logic        locked,
    output logic        sync_err,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    localparam logic [10:0] CNT_PRE  = 11'h7FE;
    localparam logic [10:0] H_PW_END = 11'(H_SYNC - 1);
    localparam logic [10:0] H_LN_END = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_FR_END = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT0   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT1   = 11'(H_SYNC + H_BP + H_VISIBLE - 1);
    localparam logic [10:0] V_ACT0   = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT1   = 11'(V_SYNC + V_BP + V_VISIBLE - 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);
    localparam logic POL = 1'(SYNC_POL);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } state_t;

    state_t state, state_nx;

    logic          hs_prev, vs_prev;
    logic [10:0]   h_cnt, v_cnt, h_nx, v_nx;
    logic          h_seen, v_seen, vs_pend, pend_nx;
    logic [GW-1:0] good, good_nx;
    logic          hs_a, vs_a, h_rise, h_fall, v_rise, fb;
    logic          line_err, frame_err, err_pulse;
    logic          h_in, v_in;

    // Sync levels normalised so that 1 always means "pulse active"
    assign hs_a   = (Hsync == POL);
    assign vs_a   = (Vsync == POL);
    assign h_rise = hs_a & ~hs_prev;
    assign h_fall = ~hs_a & hs_prev;
    assign v_rise = vs_a & ~vs_prev;
    assign fb     = h_rise & (vs_pend | v_rise);

    always_comb begin
        line_err = 1'b0;
        if (h_fall && h_cnt != H_PW_END)
            line_err = 1'b1;
        if (h_rise && h_seen && h_cnt != H_LN_END)
            line_err = 1'b1;
        if (!h_rise && h_cnt == CNT_PRE)
            line_err = 1'b1;

        frame_err = 1'b0;
        if (fb && v_seen && v_cnt != V_FR_END)
            frame_err = 1'b1;
        if (h_rise && !fb && v_cnt == CNT_PRE)
            frame_err = 1'b1;

        h_nx = h_cnt;
        if (h_rise)
            h_nx = '0;
        else if (h_cnt != CNT_MAX)
            h_nx = h_cnt + 11'd1;

        v_nx = v_cnt;
        if (fb)
            v_nx = '0;
        else if (h_rise && v_cnt != CNT_MAX)
            v_nx = v_cnt + 11'd1;

        pend_nx = fb ? 1'b0 : (vs_pend | v_rise);
    end

    always_comb begin
        state_nx  = state;
        good_nx   = good;
        err_pulse = 1'b0;
        unique case (state)
            SEARCH: begin
                if (fb) begin
                    state_nx = ALIGN;
                    good_nx  = '0;
                end
            end
            ALIGN: begin
                if (line_err || frame_err) begin
                    state_nx = SEARCH;
                end else if (fb) begin
                    good_nx = good + GW'(1);
                    if (good_nx == GOOD_LOCK)
                        state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (line_err || frame_err) begin
                    state_nx  = SEARCH;
                    err_pulse = 1'b1;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            good        <= '0;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            vs_pend     <= 1'b0;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sync_err    <= enable & err_pulse;
            frame_start <= enable & fb;
            if (enable) begin
                state   <= state_nx;
                good    <= good_nx;
                hs_prev <= hs_a;
                vs_prev <= vs_a;
                h_cnt   <= h_nx;
                v_cnt   <= v_nx;
                h_seen  <= h_seen | h_rise;
                v_seen  <= v_seen | fb;
                vs_pend <= pend_nx;
            end
        end
    end

    assign locked = (state == LOCKED);
    assign h_in   = (h_cnt >= H_ACT0) && (h_cnt <= H_ACT1);
    assign v_in   = (v_cnt >= V_ACT0) && (v_cnt <= V_ACT1);
    assign active = locked & h_in & v_in;
    assign Hpos   = active ? (h_cnt - H_ACT0) : '0;
    assign Vpos   = active ? (v_cnt - V_ACT0) : '0;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a reduced 25x13 format with a
// timestamp-based reference model of the sync recovery rules.
module tb_vga_sync_rx;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8, VF = 1, VS = 2, VB = 2;
    localparam int POL = 0, LF = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;

    logic        clk = 1'b0;
    logic        reset, enable, Hsync, Vsync;
    logic [10:0] Hpos, Vpos;
    logic        active, locked, sync_err, frame_start;
    logic [25:0] obs;

    vga_sync_rx #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .Hsync(Hsync), .Vsync(Vsync),
        .Hpos(Hpos), .Vpos(Vpos), .active(active),
        .locked(locked), .sync_err(sync_err),
        .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    assign obs = {Hpos, Vpos, active, locked, sync_err, frame_start};

    int errs = 0, chk = 0;
    int se_cnt = 0, fs_cnt = 0;

    // reference model: time-stamped edges, mode 0/1/2 = search/align/locked
    int n, t_hr, lines, mode, good;
    bit hp, vp, vpend, hseen, vseen;
    logic [25:0] exp_v;

    function automatic logic lvl(input bit a);
        return a ? 1'(POL) : ~1'(POL);
    endfunction

    function automatic int sat(input int a);
        return (a > 2047) ? 2047 : a;
    endfunction

    task automatic model_reset();
        n = 0; t_hr = 0; lines = 0; mode = 0; good = 0;
        hp = 0; vp = 0; vpend = 0; hseen = 0; vseen = 0;
        exp_v = '0;
    endtask

    task automatic model_step(input bit ha, input bit va);
        int pre_h, h, v;
        bit rise, fall, lerr, ferr, fb, serr, act;
        n++;
        pre_h = sat(n - 1 - t_hr);
        rise = ha && !hp;
        fall = !ha && hp;
        lerr = 0; ferr = 0; fb = 0; serr = 0;
        if (fall && pre_h != HS - 1) lerr = 1;
        if (rise && hseen && pre_h != HT - 1) lerr = 1;
        if (rise) begin
            hseen = 1;
            t_hr = n;
        end else if (n - t_hr == 2047) begin
            lerr = 1;
        end
        if (va && !vp) vpend = 1;
        if (rise) begin
            if (vpend) begin
                fb = 1;
                if (vseen && sat(lines) != VT - 1) ferr = 1;
                vseen = 1; vpend = 0; lines = 0;
            end else begin
                lines++;
                if (lines == 2047) ferr = 1;
            end
        end
        h = sat(n - t_hr);
        v = sat(lines);
        case (mode)
            0: if (fb) begin mode = 1; good = 0; end
            1: begin
                if (lerr || ferr) mode = 0;
                else if (fb) begin
                    good++;
                    if (good == LF) mode = 2;
                end
            end
            default: if (lerr || ferr) begin mode = 0; serr = 1; end
        endcase
        hp = ha; vp = va;
        act = (mode == 2) && h >= HA0 && h < HA0 + HV
              && v >= VA0 && v < VA0 + VV;
        exp_v = {act ? 11'(h - HA0) : 11'd0, act ? 11'(v - VA0) : 11'd0,
                 act, mode == 2, serr, fb};
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            enable = 0;
            Hsync = 1'($urandom);
            Vsync = 1'($urandom);
            @(posedge clk);
            #1;
            chk++;
            if (obs !== {exp_v[25:2], 2'b00}) begin
                errs++;
                $display("FAIL idle_freeze n=%0d got=%h want=%h",
                         n, obs, {exp_v[25:2], 2'b00});
            end
        end
    endtask

    task automatic pix(input bit ha, input bit va);
        @(negedge clk);
        enable = 1;
        Hsync = lvl(ha);
        Vsync = lvl(va);
        @(posedge clk);
        #1;
        model_step(ha, va);
        chk++;
        if (obs !== exp_v) begin
            errs++;
            $display("FAIL pixel n=%0d got=%h want=%h", n, obs, exp_v);
        end
        if (sync_err) se_cnt++;
        if (frame_start) fs_cnt++;
        idle(($urandom_range(0, 3) == 0) ? 2 : 1);
    endtask

    // fault: 0 none, 1 line one pixel short, 2 hsync one pixel narrow
    task automatic send_frame(input int fault, input int fl,
                              input int early, input int stop_at,
                              input int hold_at, input bit pchk);
        bit ha, va;
        int p;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                p = y * HT + x;
                if (p == stop_at) return;
                if (fault == 1 && y == fl && x == HT - 1) continue;
                if (p == hold_at) idle(100);
                ha = (fault == 2 && y == fl) ? (x < HS - 1) : (x < HS);
                va = (y < VS) || (early > 0 && y == VT - 1 && x >= early);
                pix(ha, va);
                if (pchk && x == HA0 && y == VA0) begin
                    chk++;
                    if ({active, Hpos, Vpos} !== {1'b1, 11'd0, 11'd0}) begin
                        errs++;
                        $display("FAIL pos_first got=%b/%0d/%0d want=1/0/0",
                                 active, Hpos, Vpos);
                    end
                end
                if (pchk && x == HA0 - 1 && y == VA0) begin
                    chk++;
                    if (active !== 1'b0) begin
                        errs++;
                        $display("FAIL pos_before got=%b want=0", active);
                    end
                end
                if (pchk && x == HA0 + HV - 1 && y == VA0 + VV - 1) begin
                    chk++;
                    if ({active, Hpos, Vpos} !==
                        {1'b1, 11'(HV - 1), 11'(VV - 1)}) begin
                        errs++;
                        $display("FAIL pos_last got=%b/%0d/%0d want=1/%0d/%0d",
                                 active, Hpos, Vpos, HV - 1, VV - 1);
                    end
                end
                if (pchk && x == HA0 + HV && y == VA0 + VV - 1) begin
                    chk++;
                    if ({active, Hpos, Vpos} !== 23'd0) begin
                        errs++;
                        $display("FAIL pos_after got=%b/%0d/%0d want=0/0/0",
                                 active, Hpos, Vpos);
                    end
                end
            end
        end
    endtask

    task automatic ideal(input int k);
        for (int i = 0; i < k; i++) send_frame(0, -1, -1, -1, -1, 0);
    endtask

    task automatic expect_lock(input string nm, input logic want);
        chk++;
        if (locked !== want) begin
            errs++;
            $display("FAIL %s locked got=%b want=%b", nm, locked, want);
        end
    endtask

    task automatic expect_cnt(input string nm, input int got, input int want);
        chk++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1; enable = 0;
        Hsync = lvl(0); Vsync = lvl(0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk++;
        if (obs !== 26'd0) begin
            errs++;
            $display("FAIL reset_state got=%h want=0", obs);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_lock();
        se_cnt = 0; fs_cnt = 0;
        ideal(2);
        expect_lock("lock_after2", 1'b0);
        ideal(1);
        expect_lock("lock_after3", 1'b1);
        expect_cnt("lock_frame_starts", fs_cnt, 3);
        expect_cnt("lock_sync_err", se_cnt, 0);
    endtask

    task automatic test_positions();
        send_frame(0, -1, -1, -1, -1, 1);
        expect_lock("positions", 1'b1);
    endtask

    task automatic test_short_line();
        se_cnt = 0;
        send_frame(1, $urandom_range(0, VT - 2), -1, -1, -1, 0);
        expect_cnt("short_sync_err", se_cnt, 1);
        expect_lock("short_unlock", 1'b0);
        ideal(2);
        expect_lock("short_relock2", 1'b0);
        ideal(1);
        expect_lock("short_relock3", 1'b1);
    endtask

    task automatic test_narrow_pulse();
        se_cnt = 0;
        send_frame(2, $urandom_range(0, VT - 1), -1, -1, -1, 0);
        expect_cnt("narrow_locked_err", se_cnt, 1);
        se_cnt = 0;
        send_frame(2, $urandom_range(0, VT - 1), -1, -1, -1, 0);
        expect_cnt("narrow_align_err", se_cnt, 0);
        expect_lock("narrow_align", 1'b0);
        ideal(3);
        expect_lock("narrow_relock", 1'b1);
    endtask

    task automatic test_saturation();
        se_cnt = 0;
        for (int i = 0; i < 2060; i++) pix(1'b0, 1'b0);
        expect_cnt("sat_sync_err", se_cnt, 1);
        expect_lock("sat_unlock", 1'b0);
        ideal(3);
        expect_lock("sat_relock", 1'b1);
    endtask

    task automatic test_early_vsync();
        se_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 3; i++)
            send_frame(0, -1, $urandom_range(1, HT - 1), -1, -1, 0);
        ideal(1);
        expect_cnt("early_frame_starts", fs_cnt, 4);
        expect_cnt("early_sync_err", se_cnt, 0);
        expect_lock("early_lock", 1'b1);
    endtask

    task automatic test_enable_hold();
        send_frame(0, -1, -1, -1, $urandom_range(1, VT * HT - 1), 0);
        expect_lock("hold_lock", 1'b1);
    endtask

    task automatic test_reset_mid();
        send_frame(0, -1, -1, $urandom_range(60, 300), -1, 0);
        expect_lock("mid_before", 1'b1);
        #3;
        reset = 1;
        #1;
        chk++;
        if (obs !== 26'd0) begin
            errs++;
            $display("FAIL mid_reset_async got=%h want=0", obs);
        end
        enable = 0;
        Hsync = lvl(0); Vsync = lvl(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        ideal(2);
        expect_lock("mid_relock2", 1'b0);
        ideal(1);
        expect_lock("mid_relock3", 1'b1);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_positions();
        test_short_line();
        test_narrow_pulse();
        test_saturation();
        test_early_vsync();
        test_enable_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, chk);
        $finish;
    end

endmodule
